// File: rtl/forwarding_lookup_if.sv
// Connection bundle between the forwarding stage and its neighbours: header parser,
// MAC table learn/read interface, egress scheduler and statistics readout.
interface forwarding_lookup_if #(
  parameter int NUM_PORTS = 4,
  parameter int CNT_W     = 16
);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic                 hdr_valid_i;
  logic                 hdr_ready_o;
  logic [47:0]          hdr_dst_i;
  logic [47:0]          hdr_src_i;
  logic [PW-1:0]        hdr_port_i;

  logic                 learn_req_o;
  logic [47:0]          learn_address_o;
  logic [PW-1:0]        learn_port_o;
  logic                 read_req_o;
  logic [47:0]          read_address_o;
  logic [PW-1:0]        read_port_i;
  logic                 read_port_valid_i;

  logic                 fwd_valid_o;
  logic                 fwd_ready_i;
  logic [NUM_PORTS-1:0] fwd_mask_o;
  logic                 fwd_drop_o;
  logic                 fwd_flood_o;

  logic [CNT_W-1:0]     stat_hit_o;
  logic [CNT_W-1:0]     stat_miss_o;
  logic [CNT_W-1:0]     stat_drop_o;

  modport slave (
    input  hdr_valid_i, hdr_dst_i, hdr_src_i, hdr_port_i,
    input  read_port_i, read_port_valid_i, fwd_ready_i,
    output hdr_ready_o, learn_req_o, learn_address_o, learn_port_o,
    output read_req_o, read_address_o,
    output fwd_valid_o, fwd_mask_o, fwd_drop_o, fwd_flood_o,
    output stat_hit_o, stat_miss_o, stat_drop_o
  );

  modport master (
    output hdr_valid_i, hdr_dst_i, hdr_src_i, hdr_port_i,
    output read_port_i, read_port_valid_i, fwd_ready_i,
    input  hdr_ready_o, learn_req_o, learn_address_o, learn_port_o,
    input  read_req_o, read_address_o,
    input  fwd_valid_o, fwd_mask_o, fwd_drop_o, fwd_flood_o,
    input  stat_hit_o, stat_miss_o, stat_drop_o
  );
endinterface

// File: rtl/forwarding_lookup.sv
// Per-frame forwarding decision: learns the source MAC, looks up the destination MAC and
// emits a unicast / flood / drop egress mask, with saturating hit/miss/drop statistics.
module forwarding_lookup #(
  parameter int NUM_PORTS = 4,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  forwarding_lookup_if.slave bus
);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [PW:0]          PORT_LIM_C  = (PW+1)'(NUM_PORTS);
  localparam logic [CNT_W-1:0]     CNT_MAX_C   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]     CNT_ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [NUM_PORTS-1:0] ALL_PORTS_C = {NUM_PORTS{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;

  logic [47:0]          dst_r;
  logic [47:0]          src_r;
  logic [PW-1:0]        port_r;

  logic                 hdr_ready_r;
  logic                 learn_req_r;
  logic                 read_req_r;
  logic                 fwd_valid_r;
  logic [NUM_PORTS-1:0] fwd_mask_r;
  logic                 fwd_drop_r;
  logic                 fwd_flood_r;
  logic [CNT_W-1:0]     stat_hit_r;
  logic [CNT_W-1:0]     stat_miss_r;
  logic [CNT_W-1:0]     stat_drop_r;

  logic                 accept_s;
  logic                 handshake_s;
  logic                 learn_ok_s;
  logic [NUM_PORTS-1:0] dec_mask_s;
  logic                 dec_drop_s;
  logic                 dec_flood_s;
  logic                 inc_hit_s;
  logic                 inc_miss_s;
  logic                 inc_drop_s;

  function automatic logic [NUM_PORTS-1:0] port_bit(input logic [PW-1:0] p);
    logic [NUM_PORTS-1:0] m;
    for (int i = 0; i < NUM_PORTS; i++) begin
      m[i] = (p == PW'(i));
    end
    return m;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    if (en && (c != CNT_MAX_C)) begin
      return c + CNT_ONE_C;
    end else begin
      return c;
    end
  endfunction

  assign accept_s    = (state_r == ST_IDLE) && bus.hdr_valid_i;
  assign handshake_s = (state_r == ST_OUT) && bus.fwd_ready_i;
  // Only learn real unicast stations; group or all-zero sources would poison the table.
  assign learn_ok_s  = !bus.hdr_src_i[40] && (bus.hdr_src_i != 48'd0);

  // Frame sequencing: next-state selection.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.hdr_valid_i) begin
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ:  state_nxt_s = ST_RESP;
      ST_RESP: state_nxt_s = ST_OUT;
      ST_OUT: begin
        if (bus.fwd_ready_i) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_OUT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Forwarding decision from the table response, in rule priority order.
  always_comb begin
    dec_mask_s  = {NUM_PORTS{1'b0}};
    dec_drop_s  = 1'b0;
    dec_flood_s = 1'b0;
    inc_hit_s   = 1'b0;
    inc_miss_s  = 1'b0;
    inc_drop_s  = 1'b0;
    if (dst_r[40]) begin
      dec_mask_s  = ALL_PORTS_C & ~port_bit(port_r);
      dec_flood_s = 1'b1;
    end else if (!bus.read_port_valid_i) begin
      dec_mask_s  = ALL_PORTS_C & ~port_bit(port_r);
      dec_flood_s = 1'b1;
      inc_miss_s  = 1'b1;
    end else if (bus.read_port_i == port_r) begin
      dec_drop_s  = 1'b1;
      inc_hit_s   = 1'b1;
      inc_drop_s  = 1'b1;
    end else if ({1'b0, bus.read_port_i} >= PORT_LIM_C) begin
      // A hit naming a non-existent port is a corrupt entry; behave as a miss.
      dec_mask_s  = ALL_PORTS_C & ~port_bit(port_r);
      dec_flood_s = 1'b1;
      inc_miss_s  = 1'b1;
    end else begin
      dec_mask_s  = port_bit(bus.read_port_i);
      inc_hit_s   = 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Descriptor capture; held from REQ through OUT so table addresses stay stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dst_r  <= 48'd0;
      src_r  <= 48'd0;
      port_r <= {PW{1'b0}};
    end else if (accept_s) begin
      dst_r  <= bus.hdr_dst_i;
      src_r  <= bus.hdr_src_i;
      port_r <= bus.hdr_port_i;
    end
  end

  // Registered handshake and table-request strobes, derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_ready_r <= 1'b1;
      read_req_r  <= 1'b0;
      learn_req_r <= 1'b0;
      fwd_valid_r <= 1'b0;
    end else begin
      hdr_ready_r <= (state_nxt_s == ST_IDLE);
      read_req_r  <= accept_s;
      learn_req_r <= accept_s && learn_ok_s;
      fwd_valid_r <= (state_nxt_s == ST_OUT);
    end
  end

  // Decision outputs: loaded in RESP, held through OUT, cleared once consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_mask_r  <= {NUM_PORTS{1'b0}};
      fwd_drop_r  <= 1'b0;
      fwd_flood_r <= 1'b0;
    end else if (state_r == ST_RESP) begin
      fwd_mask_r  <= dec_mask_s;
      fwd_drop_r  <= dec_drop_s;
      fwd_flood_r <= dec_flood_s;
    end else if (handshake_s) begin
      fwd_mask_r  <= {NUM_PORTS{1'b0}};
      fwd_drop_r  <= 1'b0;
      fwd_flood_r <= 1'b0;
    end
  end

  // Saturating statistics, updated once per frame as the decision is registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_hit_r  <= {CNT_W{1'b0}};
      stat_miss_r <= {CNT_W{1'b0}};
      stat_drop_r <= {CNT_W{1'b0}};
    end else if (state_r == ST_RESP) begin
      stat_hit_r  <= sat_inc(stat_hit_r, inc_hit_s);
      stat_miss_r <= sat_inc(stat_miss_r, inc_miss_s);
      stat_drop_r <= sat_inc(stat_drop_r, inc_drop_s);
    end
  end

  assign bus.hdr_ready_o     = hdr_ready_r;
  assign bus.learn_req_o     = learn_req_r;
  assign bus.learn_address_o = src_r;
  assign bus.learn_port_o    = port_r;
  assign bus.read_req_o      = read_req_r;
  assign bus.read_address_o  = dst_r;
  assign bus.fwd_valid_o     = fwd_valid_r;
  assign bus.fwd_mask_o      = fwd_mask_r;
  assign bus.fwd_drop_o      = fwd_drop_r;
  assign bus.fwd_flood_o     = fwd_flood_r;
  assign bus.stat_hit_o      = stat_hit_r;
  assign bus.stat_miss_o     = stat_miss_r;
  assign bus.stat_drop_o     = stat_drop_r;
endmodule

// File: tb/tb_forwarding_lookup.sv
// Randomized bench for forwarding_lookup: a cycle-level behavioural model checks every output
// every cycle; directed frames pin the model with hand-computed literal results.
module tb_forwarding_lookup;
  localparam int NUM_PORTS = 4;
  localparam int CNT_W     = 5;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  forwarding_lookup_if #(.NUM_PORTS(NUM_PORTS), .CNT_W(CNT_W)) bus ();

  forwarding_lookup #(.NUM_PORTS(NUM_PORTS), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Pins and driver status, written only by the stimulus process.
  logic       pin_en = 1'b0;
  logic [3:0] pin_mask;
  logic       pin_drop, pin_flood, pin_learn;
  int         pin_hit, pin_miss, pin_dcnt;
  logic       drv_timeout = 1'b0;

  // Model state, written only by the compare process.
  logic        busy = 1'b0;
  int          acc = -10;
  int          cyc = 0;
  logic [47:0] e_dst, e_src;
  int          e_ing;
  logic        e_learn;
  logic [3:0]  x_mask;
  logic        x_drop, x_flood, i_hit, i_miss, i_drop;
  int          m_hit = 0, m_miss = 0, m_drop = 0;
  logic        exp_req, exp_valid, rsp_v;
  int          rsp_p;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // Compare process: model of the frame timeline, checked at every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_fwd_valid", 64'(bus.fwd_valid_o), 64'd0);
        chk("rst_hdr_ready", 64'(bus.hdr_ready_o), 64'd1);
        chk("rst_reqs", 64'({bus.read_req_o, bus.learn_req_o}), 64'd0);
        chk("rst_flags", 64'({bus.fwd_mask_o, bus.fwd_drop_o, bus.fwd_flood_o}), 64'd0);
        chk("rst_stats", 64'({bus.stat_hit_o, bus.stat_miss_o, bus.stat_drop_o}), 64'd0);
        chk("rst_addr", 64'(bus.read_address_o) | 64'(bus.learn_address_o) | 64'(bus.learn_port_o), 64'd0);
        busy = 1'b0; m_hit = 0; m_miss = 0; m_drop = 0;
      end else begin
        chk("drv_wait", 64'(drv_timeout), 64'd0);
        chk("hdr_ready", 64'(bus.hdr_ready_o), 64'(!busy));
        exp_req = busy && (cyc == acc + 1);
        chk("read_req", 64'(bus.read_req_o), 64'(exp_req));
        chk("learn_req", 64'(bus.learn_req_o), 64'(exp_req && e_learn));
        if (pin_en && exp_req) chk("pin_learn", 64'(bus.learn_req_o), 64'(pin_learn));
        if (busy && cyc > acc) begin
          chk("read_addr", 64'(bus.read_address_o), 64'(e_dst));
          chk("learn_addr", 64'(bus.learn_address_o), 64'(e_src));
          chk("learn_port", 64'(bus.learn_port_o), 64'(e_ing));
        end
        if (busy && cyc == acc + 2) begin
          rsp_v = bus.read_port_valid_i;
          rsp_p = int'(bus.read_port_i);
          x_drop = 1'b0; x_flood = 1'b0; i_hit = 1'b0; i_miss = 1'b0; i_drop = 1'b0;
          x_mask = 4'(((1 << NUM_PORTS) - 1) - (1 << e_ing));
          if (e_dst[40]) x_flood = 1'b1;
          else if (!rsp_v) begin x_flood = 1'b1; i_miss = 1'b1; end
          else if (rsp_p == e_ing) begin x_mask = 4'd0; x_drop = 1'b1; i_hit = 1'b1; i_drop = 1'b1; end
          else if (rsp_p >= NUM_PORTS) begin x_flood = 1'b1; i_miss = 1'b1; end
          else begin x_mask = 4'(1 << rsp_p); i_hit = 1'b1; end
        end
        exp_valid = busy && (cyc >= acc + 3);
        if (busy && cyc == acc + 3) begin
          if (i_hit && m_hit < CNT_MAX) m_hit++;
          if (i_miss && m_miss < CNT_MAX) m_miss++;
          if (i_drop && m_drop < CNT_MAX) m_drop++;
        end
        chk("fwd_valid", 64'(bus.fwd_valid_o), 64'(exp_valid));
        if (exp_valid) begin
          chk("fwd_mask", 64'(bus.fwd_mask_o), 64'(x_mask));
          chk("fwd_drop", 64'(bus.fwd_drop_o), 64'(x_drop));
          chk("fwd_flood", 64'(bus.fwd_flood_o), 64'(x_flood));
        end
        chk("stat_hit", 64'(bus.stat_hit_o), 64'(m_hit));
        chk("stat_miss", 64'(bus.stat_miss_o), 64'(m_miss));
        chk("stat_drop", 64'(bus.stat_drop_o), 64'(m_drop));
        if (pin_en && busy && cyc == acc + 3) begin
          chk("pin_mask", 64'(bus.fwd_mask_o), 64'(pin_mask));
          chk("pin_drop", 64'(bus.fwd_drop_o), 64'(pin_drop));
          chk("pin_flood", 64'(bus.fwd_flood_o), 64'(pin_flood));
          chk("pin_hit", 64'(bus.stat_hit_o), 64'(pin_hit));
          chk("pin_miss", 64'(bus.stat_miss_o), 64'(pin_miss));
          chk("pin_dcnt", 64'(bus.stat_drop_o), 64'(pin_dcnt));
        end
        if (exp_valid && bus.fwd_ready_i) begin
          busy = 1'b0;
        end else if (!busy && bus.hdr_valid_i) begin
          busy = 1'b1; acc = cyc;
          e_dst = bus.hdr_dst_i; e_src = bus.hdr_src_i; e_ing = int'(bus.hdr_port_i);
          e_learn = !bus.hdr_src_i[40] && (bus.hdr_src_i != 48'd0);
        end
      end
      cyc++;
    end
  end

  task automatic send_frame(input logic [47:0] dst, input logic [47:0] src, input logic [1:0] ing,
                            input logic hit, input logic [1:0] rp, input int hold, input logic junk);
    int n;
    n = 0;
    while (!bus.hdr_ready_o && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) drv_timeout = 1'b1;
    bus.hdr_valid_i = 1'b1; bus.hdr_dst_i = dst; bus.hdr_src_i = src; bus.hdr_port_i = ing;
    @(posedge clk); #1;
    bus.hdr_valid_i = junk;
    if (junk) begin
      bus.hdr_dst_i = {16'($urandom), 32'($urandom)};
      bus.hdr_src_i = {16'($urandom), 32'($urandom)};
      bus.hdr_port_i = 2'($urandom);
    end
    bus.read_port_i = 2'($urandom); bus.read_port_valid_i = 1'($urandom);
    bus.fwd_ready_i = 1'($urandom);
    @(posedge clk); #1;
    bus.read_port_i = rp; bus.read_port_valid_i = hit; bus.fwd_ready_i = 1'($urandom);
    @(posedge clk); #1;
    bus.read_port_i = 2'($urandom); bus.read_port_valid_i = 1'($urandom);
    bus.fwd_ready_i = 1'b0;
    repeat (hold) begin @(posedge clk); #1; end
    bus.fwd_ready_i = 1'b1; bus.hdr_valid_i = 1'b0;
    @(posedge clk); #1;
    bus.fwd_ready_i = 1'b0;
  endtask

  task automatic run_pin(input logic [47:0] dst, input logic [47:0] src, input logic [1:0] ing,
                         input logic hit, input logic [1:0] rp, input int hold, input logic junk,
                         input logic [3:0] msk, input logic drp, input logic fld,
                         input int ph, input int pm, input int pd, input logic lrn);
    pin_mask = msk; pin_drop = drp; pin_flood = fld;
    pin_hit = ph; pin_miss = pm; pin_dcnt = pd; pin_learn = lrn;
    pin_en = 1'b1;
    send_frame(dst, src, ing, hit, rp, hold, junk);
    pin_en = 1'b0;
  endtask

  task automatic random_frames(input int count);
    logic [47:0] d, s;
    for (int k = 0; k < count; k++) begin
      d = {16'($urandom), 32'($urandom)};
      d[40] = ($urandom_range(0, 3) == 0);
      s = {16'($urandom), 32'($urandom)};
      s[40] = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) s = 48'd0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send_frame(d, s, 2'($urandom), ($urandom_range(0, 2) != 0), 2'($urandom),
                 $urandom_range(0, 3), 1'($urandom));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.hdr_valid_i = 1'b0; bus.hdr_dst_i = 48'd0; bus.hdr_src_i = 48'd0; bus.hdr_port_i = 2'd0;
    bus.read_port_i = 2'd0; bus.read_port_valid_i = 1'b0; bus.fwd_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    // Unicast hit, miss, broadcast, same-port filter, backpressure with multicast source.
    run_pin(48'h0200_0000_0002, 48'h0200_0000_0011, 2'd0, 1'b1, 2'd2, 0, 1'b0,
            4'b0100, 1'b0, 1'b0, 1, 0, 0, 1'b1);
    run_pin(48'h0200_0000_0003, 48'h0200_0000_0013, 2'd1, 1'b0, 2'd0, 1, 1'b0,
            4'b1101, 1'b0, 1'b1, 1, 1, 0, 1'b1);
    run_pin(48'hFFFF_FFFF_FFFF, 48'h0200_0000_0014, 2'd3, 1'b1, 2'd0, 0, 1'b0,
            4'b0111, 1'b0, 1'b1, 1, 1, 0, 1'b1);
    run_pin(48'h0200_0000_0005, 48'h0200_0000_0015, 2'd2, 1'b1, 2'd2, 2, 1'b0,
            4'b0000, 1'b1, 1'b0, 2, 1, 1, 1'b1);
    run_pin(48'h0200_0000_0006, 48'h0100_0000_0001, 2'd0, 1'b0, 2'd1, 10, 1'b1,
            4'b1110, 1'b0, 1'b1, 2, 2, 1, 1'b0);
    random_frames(260);
    // Reset asserted while a decision is waiting in OUT.
    bus.hdr_valid_i = 1'b1; bus.hdr_dst_i = 48'h0200_0000_0007;
    bus.hdr_src_i = 48'h0200_0000_0008; bus.hdr_port_i = 2'd1;
    @(posedge clk); #1;
    bus.hdr_valid_i = 1'b0; bus.fwd_ready_i = 1'b0;
    @(posedge clk); #1;
    bus.read_port_valid_i = 1'b1; bus.read_port_i = 2'd3;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    random_frames(20);
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before end of stimulus");
    $fatal(1, "watchdog");
  end
endmodule
